// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the adder_arbiter block: FSM state encoding,
// default parameter values and the signed clamp used by the saturating build.
package adder_arbiter_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 8;

   // Clamp a signed value into the signed range of an sw-bit number.
   // sat reports whether clamping took place.
   function automatic logic signed [63:0] sat_clamp(input  logic signed [63:0] v,
                                                    input  int                 sw,
                                                    output logic               sat);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi  = (64'sd1 <<< (sw - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (sw - 1));
      sat = 1'b0;
      sat_clamp = v;
      if (v > hi) begin
         sat_clamp = hi;
         sat       = 1'b1;
      end else if (v < lo) begin
         sat_clamp = lo;
         sat       = 1'b1;
      end
   endfunction

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin picker: grants the lowest-index active request at or after ptr,
// wrapping modulo NREQ. Purely combinational; grant is one-hot or zero.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            gnt_any
);

   // Scan from ptr upward, first active request wins
   always_comb begin
      int idx;
      gnt     = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (en && !gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_id   = IDW'(idx);
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shared signed adder (x + y + cin) arbitrated round-robin among NREQ
// requesters, with a single-entry result register (EMPTY/FULL).
// Optional feature macro: ADDER_ARBITER_SAT_EN -- clamp results that overflow
// the SWIDTH signed range and flag them on rsp_sat; otherwise results wrap.
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int NREQ   = DEF_NREQ,
   parameter int WIDTH  = DEF_WIDTH,
   parameter int SWIDTH = WIDTH + 1,
   parameter int IDW    = $clog2(NREQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*WIDTH-1:0]    req_x,
   input  logic [NREQ*WIDTH-1:0]    req_y,
   input  logic [NREQ-1:0]          req_cin,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic signed [SWIDTH-1:0] rsp_sum,
   output logic                     rsp_zero,
   output logic [IDW-1:0]           rsp_id,
   output logic                     rsp_sat
);

   state_t                     state_q, state_d;
   logic [IDW-1:0]             ptr_q, ptr_d;
   logic [IDW-1:0]             id_q, id_d;
   logic signed [SWIDTH-1:0]   sum_q, sum_d;
   logic                       zero_q, zero_d;
   logic                       sat_q, sat_d;

   logic                       can_accept;
   logic                       xfer;
   logic [NREQ-1:0]            gnt;
   logic [IDW-1:0]             gnt_id;
   logic signed [WIDTH-1:0]    x_sel, y_sel;
   logic                       cin_sel;
   logic signed [WIDTH:0]      raw;
   logic signed [SWIDTH-1:0]   sum_n;
   logic                       sat_n;

   // Register can take a new result when empty or being drained this cycle;
   // reset gating keeps req_ready low while rst is high.
   assign can_accept = (state_q == ST_EMPTY) || rsp_ready;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .en      (can_accept && !rst),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_any (xfer)
   );

   assign req_ready = gnt;

   // Select the granted requester's operands and add at WIDTH+1 bits
   always_comb begin
      x_sel   = req_x[gnt_id*WIDTH +: WIDTH];
      y_sel   = req_y[gnt_id*WIDTH +: WIDTH];
      cin_sel = req_cin[gnt_id];
      raw     = {x_sel[WIDTH-1], x_sel} + {y_sel[WIDTH-1], y_sel}
              + {{WIDTH{1'b0}}, cin_sel};
   end

   // Fit the full-precision sum into SWIDTH bits (clamp or wrap)
   always_comb begin
`ifdef ADDER_ARBITER_SAT_EN
      sat_n = 1'b0;
      sum_n = SWIDTH'(sat_clamp(64'(raw), SWIDTH, sat_n));
`else
      sum_n = SWIDTH'(raw);
      sat_n = 1'b0;
`endif
   end

   // Next-state: fill on transfer, drain when consumer takes without refill
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sum_d   = sum_q;
      zero_d  = zero_q;
      id_d    = id_q;
      sat_d   = sat_q;
      case (state_q)
         ST_EMPTY: if (xfer) state_d = ST_FULL;
         ST_FULL:  if (rsp_ready && !xfer) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
      if (xfer) begin
         sum_d  = sum_n;
         zero_d = (sum_n == '0);
         id_d   = gnt_id;
         sat_d  = sat_n;
         ptr_d  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      end
   end

   // State and result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         ptr_q   <= '0;
         sum_q   <= '0;
         zero_q  <= 1'b0;
         id_q    <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sum_q   <= sum_d;
         zero_q  <= zero_d;
         id_q    <= id_d;
         sat_q   <= sat_d;
      end
   end

   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_sum   = sum_q;
   assign rsp_zero  = zero_q;
   assign rsp_id    = id_q;
   assign rsp_sat   = sat_q;

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares one signed adder (x + y + cin) among NREQ requesters. Each requester presents operands with a valid/ready handshake; the block grants one per cycle, computes the sum, and holds it in a single-entry output register with a zero flag and the requester ID. Sits between the per-channel operand sources and the shared result consumer in the arithmetic datapath.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, signed operand width
- SWIDTH, WIDTH+1, signed result width (≥ WIDTH)
- IDW, $clog2(NREQ), requester ID width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester grant/accept (one-hot or zero)
- req_x  in  NREQ*WIDTH  signed x operands, requester i at [i*WIDTH +: WIDTH]
- req_y  in  NREQ*WIDTH  signed y operands, same packing
- req_cin  in  NREQ  carry-in per requester
- rsp_valid  out  1  result register holds valid data
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  SWIDTH  signed result
- rsp_zero  out  1  rsp_sum == 0
- rsp_id  out  IDW  index of granted requester
- rsp_sat  out  1  result was clamped (see Configuration)

## Operation
- Two-state FSM on output register: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
- can_accept = EMPTY or (FULL and rsp_ready).
- Arbitration combinational: when can_accept, grant lowest index ≥ ptr with req_valid set, wrapping modulo NREQ; req_ready[g]=1 only for that index, all others 0. req_ready is 0 for all when !can_accept.
- Transfer on requester g occurs when req_valid[g] & req_ready[g].
- On transfer: rsp_sum <= x+y+cin computed at WIDTH+1 bits signed, then sign-extended or truncated to SWIDTH; rsp_zero <= (stored sum == 0); rsp_id <= g; ptr <= (g+1) mod NREQ; state -> FULL.
- FULL with rsp_ready and no transfer -> EMPTY. FULL without rsp_ready: outputs held stable.
- ptr unchanged on cycles without transfer.
- cin treated as unsigned 0/1.

## Timing
- Reset values: rsp_valid=0, rsp_sum=0, rsp_zero=0, rsp_id=0, rsp_sat=0, ptr=0, state EMPTY; req_ready=0 only while rst asserted.
- Latency: transfer in cycle T -> rsp_valid at T+1.
- Throughput: one result per cycle when rsp_ready held high (simultaneous drain and refill in FULL).
- req_ready depends combinationally on req_valid, ptr, state and rsp_ready; no dependence of req_ready on operand values.
- Requester may drop req_valid without transfer; no state changes.
- rst asserted mid-operation: pending result discarded, all outputs return to reset values immediately.

## Configuration
- ADDER_ARBITER_SAT_EN defined: if WIDTH+1-bit sum exceeds SWIDTH signed range, rsp_sum clamps to max/min SWIDTH value and rsp_sat=1 with that result; rsp_zero computed on clamped value.
- Undefined: wrap (truncate) to SWIDTH, rsp_sat tied 0. With default SWIDTH=WIDTH+1 no overflow ever occurs in either build.

## Structure
- Package adder_arbiter_pkg: FSM state enum (ST_EMPTY, ST_FULL), default parameter constants, function for signed clamp.
- One sub-module: rr_arbiter (NREQ-wide request vector, ptr, enable -> one-hot grant plus encoded index); datapath and FSM in top.

## Test plan
- Single requester: NREQ=4, req 2 sends x=5, y=-5, cin=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=0, rsp_zero=1, rsp_id=2.
- Round-robin fairness: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,… one per cycle, ptr wrap verified.
- Backpressure: rsp_ready=0 after first result (x=3,y=4,cin=1 -> 8) -> rsp_sum held 8, all req_ready=0 until rsp_ready=1, then next grant same cycle.
- Extremes WIDTH=8, SWIDTH=8: x=127, y=1, cin=0 -> without macro rsp_sum=-128, rsp_sat=0; with ADDER_ARBITER_SAT_EN rsp_sum=127, rsp_sat=1; x=-128, y=-1 -> -128 with sat=1 (macro) / 127 (wrap).
- Reset mid-operation: rst high while FULL and requests pending -> rsp_valid=0, ptr=0 immediately; after release, requester 0 granted first.
- Valid withdrawal: req 1 raises then drops valid while FULL and rsp_ready=0 -> no transfer, ptr unchanged.
